// File: rtl/reg_file_32x32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_32x32_pkg
// Brief    : Shared widths, register count and clear-sequencer state encoding
//            for the 32 x 32 register file.
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_32x32_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    // Clear sequencer states: CLEAR walks every index, READY is terminal.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_clr_seq.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_clr_seq
// Brief    : Post-reset clear sequencer. Walks every register index once,
//            requesting a zero write for each, then raises ready for good.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_clr_seq #(
    parameter int ADDR_W = reg_file_32x32_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready
);
    import reg_file_32x32_pkg::*;

    state_t            r_state_q;
    state_t            w_state_d;
    logic [ADDR_W-1:0] r_cnt_q;
    logic [ADDR_W-1:0] w_cnt_d;
    logic              r_ready_q;
    logic              w_ready_d;

    // Next-state: step the index while clearing, leave READY only via reset.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        if (r_state_q == CLEAR) begin
            w_cnt_d = r_cnt_q + 1'b1;
            if (r_cnt_q == '1) begin
                w_state_d = READY;
            end
        end
        w_ready_d = (w_state_d == READY);
    end

    // State, counter and the registered ready decode; reset restarts the walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= CLEAR;
            r_cnt_q   <= '0;
            r_ready_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_ready_q <= w_ready_d;
        end
    end

    // No clear write happens on a reset edge: reset alone never touches data.
    assign clr_en  = (r_state_q == CLEAR) && rst_n;
    assign clr_idx = r_cnt_q;
    assign ready   = r_ready_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_32x32
// Brief    : 32-entry register file, one write port, two combinational read
//            ports with write-first bypass, register 0 hard-wired to zero,
//            cleared by a sequencer after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_32x32 #(
    parameter int DATA_W = reg_file_32x32_pkg::DATA_W,
    parameter int ADDR_W = reg_file_32x32_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Ready
);
    import reg_file_32x32_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_ready;

    logic              w_user_wr;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [DATA_W-1:0] w_wr_data;

    logic [DATA_W-1:0] r_regs_q [DEPTH];

    reg_file_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .clr_en  (w_clr_en),
        .clr_idx (w_clr_idx),
        .ready   (w_ready)
    );

    // Merge the clear walk and the user write into one array write port;
    // the two are mutually exclusive because user writes need ready.
    always_comb begin
        w_user_wr = w_ready && Rst_n && RegWrite && (WriteReg != '0);
        w_wr_en   = w_clr_en || w_user_wr;
        w_wr_idx  = w_clr_en ? w_clr_idx : WriteReg;
        w_wr_data = w_clr_en ? '0 : WriteData;
    end

    // Storage array; deliberately not reset so only the clear walk zeroes it.
    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_regs_q[w_wr_idx] <= w_wr_data;
        end
    end

    // Read port 1: zero until ready, then bypass, then x0, then the array.
    always_comb begin
        if (!w_ready || !Rst_n) begin
            ReadData1 = '0;
        end else if (w_user_wr && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
        end else if (ReadReg1 == '0) begin
            ReadData1 = '0;
        end else begin
            ReadData1 = r_regs_q[ReadReg1];
        end
    end

    // Read port 2: same priority as port 1, bypassed independently.
    always_comb begin
        if (!w_ready || !Rst_n) begin
            ReadData2 = '0;
        end else if (w_user_wr && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
        end else if (ReadReg2 == '0) begin
            ReadData2 = '0;
        end else begin
            ReadData2 = r_regs_q[ReadReg2];
        end
    end

    assign Ready = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_32x32
// Brief    : Self-checking bench for reg_file_32x32 against an array-based
//            behavioural model: directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_32x32;

    logic        Clk;
    logic        Rst_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: register contents, ready flag, edges since release.
    logic [31:0] m_regs [32];
    bit          m_ready;
    int          m_edges;

    reg_file_32x32 #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .Ready     (Ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] rr, input bit rw,
                                               input logic [4:0] wr, input logic [31:0] wd,
                                               input bit rstn);
        if (!m_ready || !rstn)           return 32'h0;
        if (rw && wr != 5'd0 && wr == rr) return wd;
        return m_regs[rr];
    endfunction

    // One clock: drive, check reads/Ready mid-cycle, then advance the model.
    task automatic cycle(input bit rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input bit rstn,
                         input string tag);
        Rst_n     = rstn;
        RegWrite  = rw;
        WriteReg  = wr;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
        @(negedge Clk);
        check_val({tag, "_rd1"}, ReadData1, model_read(r1, rw, wr, wd, rstn));
        check_val({tag, "_rd2"}, ReadData2, model_read(r2, rw, wr, wd, rstn));
        check_val({tag, "_ready"}, {31'b0, Ready}, {31'b0, m_ready});
        @(posedge Clk);
        if (!rstn) begin
            m_ready = 0;
            m_edges = 0;
        end else if (m_ready) begin
            if (rw && wr != 5'd0) m_regs[wr] = wd;
        end else begin
            m_edges++;
            if (m_edges == 32) begin
                m_ready = 1;
                for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            end
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2, input string tag);
        cycle(1'b0, 5'd0, 32'h0, r1, r2, 1'b1, tag);
    endtask

    task automatic random_cycle(input int rst_odds);
        bit          rw;
        logic [4:0]  wr, r1, r2;
        logic [31:0] wd;
        bit          rstn;
        rw   = ($urandom_range(0, 3) != 0);
        wr   = 5'($urandom_range(0, 31));
        wd   = $urandom;
        r1   = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
        r2   = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
        rstn = (rst_odds == 0) || ($urandom_range(1, rst_odds) != 1);
        cycle(rw, wr, wd, r1, r2, rstn, "rand");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_ready = 0;
        m_edges = 0;

        // Hold reset for two edges.
        Rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_val("reset_ready", {31'b0, Ready}, 32'h0);

        // Clear walk: a write aimed at reg3 while cnt==10 must be dropped.
        for (int i = 0; i < 32; i++) begin
            if (i == 10) cycle(1'b1, 5'd3, 32'hAA, 5'd3, 5'd3, 1'b1, "clr_wr");
            else         cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd3, 5'd7, 1'b1, "clr");
        end
        check_val("ready_after_32", {31'b0, Ready}, 32'h1);

        // Every register reads zero after the clear.
        for (int i = 0; i < 32; i += 2) idle_read(5'(i), 5'(i + 1), "zero_sweep");

        // Basic write then read back.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b1, "wr5");
        idle_read(5'd5, 5'd6, "rd5");
        check_val("rd5_direct", ReadData1, 32'hDEADBEEF);

        // Register zero ignores writes, same cycle and afterwards.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "wr0");
        idle_read(5'd0, 5'd5, "rd0");

        // Dual-port bypass of the value being written.
        cycle(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, 1'b1, "bypass");
        idle_read(5'd9, 5'd3, "rd9_rd3");

        // Random traffic without reset.
        repeat (300) random_cycle(0);

        // Mid-operation reset: reg7 must be zero once ready again.
        cycle(1'b1, 5'd7, 32'h55, 5'd7, 5'd0, 1'b1, "wr7");
        idle_read(5'd7, 5'd0, "rd7");
        cycle(1'b1, 5'd7, 32'hCAFE, 5'd7, 5'd7, 1'b0, "rst_pulse");
        for (int i = 0; i < 40 && !m_ready; i++) idle_read(5'd7, 5'd5, "reclr");
        check_val("ready_again", {31'b0, Ready}, 32'h1);
        idle_read(5'd7, 5'd5, "rd7_after");

        // Reset in the middle of a clear walk restarts it.
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, "rst_a");
        repeat (15) idle_read(5'd1, 5'd2, "part_clr");
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, "rst_b");
        for (int i = 0; i < 40 && !m_ready; i++) idle_read(5'd1, 5'd2, "reclr2");

        // Random traffic with occasional resets.
        repeat (600) random_cycle(64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
